iwr_param_responder: RTL

- Responder end of the layer-parameter address/data channel used by the IBRAM write controller.
- Holds a per-layer parameter table, loaded by the host/config path before a run.
- Accepts one layer-index request on the address channel and returns the packed parameter word on the data channel.
- One request outstanding at a time; flags out-of-range requests and the last configured layer.

---
 rtl/iwr_param_pkg.sv | 39 +++
 rtl/param_regfile.sv | 31 +++
 rtl/iwr_param_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/iwr_param_pkg.sv
// Shared types and field layout for the layer-parameter responder.
// Default field widths follow the reference network limits (128 oc, 45 ic, 5x5 kernel).
package iwr_param_pkg;

   typedef enum logic [1:0] {
      CFG   = 2'd0,
      ARMED = 2'd1,
      FETCH = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int OC_W        = $clog2(128);
   localparam int IC_W        = $clog2(45);
   localparam int K_W         = $clog2(5);
   localparam int OCK_W       = $clog2(128 * 5);
   localparam int PARAM_WIDTH = OC_W + IC_W + K_W + OCK_W;

   // Packed word layout, LSB first: oc*k product, kernel, in-channels, out-channels.
   localparam int OCK_LSB = 0;
   localparam int K_LSB   = OCK_LSB + OCK_W;
   localparam int IC_LSB  = K_LSB + K_W;
   localparam int OC_LSB  = IC_LSB + IC_W;

   function automatic logic [PARAM_WIDTH-1:0] pack_params(
      input logic [OC_W-1:0]  oc,
      input logic [IC_W-1:0]  ic,
      input logic [K_W-1:0]   k,
      input logic [OCK_W-1:0] ock
   );
      logic [PARAM_WIDTH-1:0] w;
      w = '0;
      w[OC_LSB  +: OC_W]  = oc;
      w[IC_LSB  +: IC_W]  = ic;
      w[K_LSB   +: K_W]   = k;
      w[OCK_LSB +: OCK_W] = ock;
      return w;
   endfunction

endpackage

// File: rtl/param_regfile.sv
// Per-layer parameter storage: one write port, one registered read port.
// Storage is deliberately not reset; contents are only meaningful after a config load.
module param_regfile #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 26,
   parameter int AW    = 2
)(
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/iwr_param_responder.sv
// Responder for the IBRAM write controller's layer-parameter channel: one index request in,
// one packed parameter word out, with out-of-range and last-layer qualifiers.
module iwr_param_responder #(
   parameter int MAX_OUT_CHANNEL = 128,
   parameter int MAX_IN_CHANNEL  = 45,
   parameter int MAX_KERNEL_SIZE = 5,
   parameter int MAX_NUM_LAYERS  = 4,
   parameter int PARAM_WIDTH     = $clog2(MAX_OUT_CHANNEL) + $clog2(MAX_IN_CHANNEL)
                                 + $clog2(MAX_KERNEL_SIZE)
                                 + $clog2(MAX_OUT_CHANNEL * MAX_KERNEL_SIZE),
   parameter int LAYER_W         = (MAX_NUM_LAYERS > 1) ? $clog2(MAX_NUM_LAYERS) : 1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_wr_en,
   input  logic [LAYER_W-1:0]     cfg_wr_addr,
   input  logic [PARAM_WIDTH-1:0] cfg_wr_data,
   input  logic [LAYER_W:0]       cfg_num_layers,
   input  logic                   cfg_commit,
   input  logic                   cfg_clear,
   output logic                   cfg_loaded,
   input  logic [PARAM_WIDTH-1:0] param_addr_iwr2,
   input  logic                   param_addr_valid_iwr2,
   output logic                   param_addr_ready_iwr2,
   output logic [PARAM_WIDTH-1:0] param_data_iwr2,
   output logic                   param_data_valid_iwr2,
   input  logic                   param_data_ready_iwr2,
   output logic                   param_err,
   output logic                   param_last
);
   import iwr_param_pkg::*;

   localparam logic [LAYER_W:0] MAX_NL = (LAYER_W+1)'(MAX_NUM_LAYERS);

   state_t                 state_q;
   state_t                 state_nxt;
   logic [LAYER_W:0]       num_layers_q;
   logic                   addr_rdy_q;
   logic                   loaded_q;
   logic                   addr_hs;
   logic                   resp_hs;
   logic                   commit_ok;
   logic                   tbl_we;
   logic                   tbl_re;
   logic [PARAM_WIDTH-1:0] nl_ext;
   logic [PARAM_WIDTH-1:0] idx_p0;
   logic [PARAM_WIDTH-1:0] rd_data_p1;
   logic                   vld_p1;
   logic                   err_p1;
   logic                   last_p1;

   always_comb begin
      state_nxt = state_q;
      addr_hs   = 1'b0;
      resp_hs   = 1'b0;
      commit_ok = 1'b0;
      tbl_we    = 1'b0;
      tbl_re    = 1'b0;
      unique case (state_q)
         CFG: begin
            tbl_we    = cfg_wr_en;
            commit_ok = cfg_commit && (cfg_num_layers != '0) && (cfg_num_layers <= MAX_NL);
            if (commit_ok) begin
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            addr_hs = param_addr_valid_iwr2;
            if (addr_hs) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            tbl_re    = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            resp_hs = param_data_ready_iwr2;
            if (resp_hs) begin
               state_nxt = ARMED;
            end
         end
         default: state_nxt = CFG;
      endcase
      // Clear aborts everything, including a write or commit landing in the same cycle.
      if (cfg_clear) begin
         state_nxt = CFG;
         addr_hs   = 1'b0;
         resp_hs   = 1'b0;
         commit_ok = 1'b0;
         tbl_we    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CFG;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Stage p0: index captured on the address handshake
   always_ff @(posedge clk) begin
      if (addr_hs) begin
         idx_p0 <= param_addr_iwr2;
      end
   end

   param_regfile #(
      .DEPTH (MAX_NUM_LAYERS),
      .WIDTH (PARAM_WIDTH),
      .AW    (LAYER_W)
   ) u_regfile (
      .clk   (clk),
      .we    (tbl_we && !rst),
      .waddr (cfg_wr_addr),
      .wdata (cfg_wr_data),
      .re    (tbl_re),
      .raddr (idx_p0[LAYER_W-1:0]),
      .rdata (rd_data_p1)
   );

   assign nl_ext = PARAM_WIDTH'(num_layers_q);

   // Stage p1: table word plus qualifiers, held for the whole response phase
   always_ff @(posedge clk) begin
      if (rst) begin
         num_layers_q <= '0;
         addr_rdy_q   <= 1'b0;
         loaded_q     <= 1'b0;
         vld_p1       <= 1'b0;
         err_p1       <= 1'b0;
         last_p1      <= 1'b0;
      end else begin
         addr_rdy_q <= (state_nxt == ARMED);
         loaded_q   <= (state_nxt != CFG);
         vld_p1     <= (state_nxt == RESP);
         if (commit_ok) begin
            num_layers_q <= cfg_num_layers;
         end
         if (state_q == FETCH) begin
            err_p1  <= (idx_p0 >= nl_ext);
            last_p1 <= (idx_p0 == (nl_ext - PARAM_WIDTH'(1)));
         end
      end
   end

   // Low index bits of an out-of-range request may alias a real entry, so data is masked on err.
   assign param_data_iwr2       = (vld_p1 && !err_p1) ? rd_data_p1 : '0;
   assign param_data_valid_iwr2 = vld_p1;
   assign param_err             = vld_p1 && err_p1;
   assign param_last            = vld_p1 && last_p1;
   assign param_addr_ready_iwr2 = addr_rdy_q;
   assign cfg_loaded            = loaded_q;

endmodule
